decode_execute_register: RTL

//  ID/EX pipeline register directly downstream of the GPR file. Captures both read ports plus decode fields

---
 rtl/decode_execute_register.sv | 92 +++++++++
 1 files changed

// File: rtl/decode_execute_register.sv
// decode_execute_register: ID/EX pipeline register with WB bypass, load-use bubble, stall hold and flush
module decode_execute_register #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_SIZE  = 5,
  parameter int CONTROL_WIDTH = 16
) (
  input  logic                     system_clock,
  input  logic                     system_reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [ADDRESS_SIZE-1:0]  id_rs,
  input  logic [ADDRESS_SIZE-1:0]  id_rt,
  input  logic                     id_reads_rs,
  input  logic                     id_reads_rt,
  input  logic [DATA_WIDTH-1:0]    id_read_data_1,
  input  logic [DATA_WIDTH-1:0]    id_read_data_2,
  input  logic [DATA_WIDTH-1:0]    id_immediate,
  input  logic [CONTROL_WIDTH-1:0] id_control,
  input  logic [ADDRESS_SIZE-1:0]  id_dest,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     wb_write_enable,
  input  logic [ADDRESS_SIZE-1:0]  wb_write_address,
  input  logic [DATA_WIDTH-1:0]    wb_write_data,
  input  logic                     ex_stall,
  input  logic                     flush,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_operand_1,
  output logic [DATA_WIDTH-1:0]    ex_operand_2,
  output logic [DATA_WIDTH-1:0]    ex_immediate,
  output logic [CONTROL_WIDTH-1:0] ex_control,
  output logic [ADDRESS_SIZE-1:0]  ex_rs,
  output logic [ADDRESS_SIZE-1:0]  ex_rt,
  output logic [ADDRESS_SIZE-1:0]  ex_dest,
  output logic                     hazard_stall
);
  logic                  wb_live;
  logic [DATA_WIDTH-1:0] cap_1;
  logic [DATA_WIDTH-1:0] cap_2;
  logic                  hold_hit_1;
  logic                  hold_hit_2;
  logic                  bubble;
  // A GPR write lands on the same edge we capture, so the read ports still show the old value
  always_comb begin
    wb_live      = wb_write_enable && wb_write_address != '0;
    cap_1        = (wb_live && wb_write_address == id_rs) ? wb_write_data : id_read_data_1;
    cap_2        = (wb_live && wb_write_address == id_rt) ? wb_write_data : id_read_data_2;
    hold_hit_1   = wb_live && wb_write_address == ex_rs;
    hold_hit_2   = wb_live && wb_write_address == ex_rt;
    hazard_stall = !system_reset && id_valid && ex_valid && ex_mem_read && ex_reg_write &&
                   ex_dest != '0 && ((id_reads_rs && id_rs == ex_dest) || (id_reads_rt && id_rt == ex_dest));
    bubble       = flush || (!ex_stall && hazard_stall);
  end
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_pc        <= '0;
      ex_operand_1 <= '0;
      ex_operand_2 <= '0;
      ex_immediate <= '0;
      ex_control   <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dest      <= '0;
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_control   <= '0;
    end else if (ex_stall) begin
      ex_operand_1 <= hold_hit_1 ? wb_write_data : ex_operand_1;
      ex_operand_2 <= hold_hit_2 ? wb_write_data : ex_operand_2;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_control   <= id_valid ? id_control : '0;
      ex_pc        <= id_pc;
      ex_operand_1 <= cap_1;
      ex_operand_2 <= cap_2;
      ex_immediate <= id_immediate;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_dest      <= id_dest;
    end
  end
endmodule
